// File: rtl/inst_fetch_responder.sv
// inst_fetch_responder: IF-side fetch responder running the req/addr_ok/data_ok handshake to the instruction bus.
// Optional feature macro: IFR_TIMEOUT_EN enables the WAIT-state timeout counter.
module inst_fetch_responder #(
    parameter logic [31:0] NOP_INST       = 32'h0000_0000,
    parameter logic [7:0]  TIMEOUT_CYCLES = 8'd255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        fetch_en,
    input  logic        flush,
    output logic [31:0] if_inst,
    output logic        delay_hard,
    output logic        IADEE,
    output logic        IADFE,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    input  logic        inst_err
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, VALID} state_t;

    state_t      state_q;
    logic        drop_q;
    logic [31:0] if_inst_q;
    logic [31:0] inst_addr_q;
    logic        iadee_q;
    logic        iadfe_q;
    logic        misaligned;
`ifdef IFR_TIMEOUT_EN
    logic [7:0]  cnt_q;
`else
    logic [7:0]  unused_timeout;
    assign unused_timeout = TIMEOUT_CYCLES;
`endif

    assign misaligned = |pc[1:0];
    assign inst_req   = state_q == REQ;
    assign inst_addr  = inst_addr_q;
    assign if_inst    = if_inst_q;
    assign IADEE      = iadee_q;
    assign IADFE      = iadfe_q;
    assign delay_hard = ~reset & fetch_en & (state_q != VALID);

    // Fetch FSM; a pending drop discards the data beat of a flushed or timed-out access
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            drop_q      <= 1'b0;
            if_inst_q   <= 32'h0;
            inst_addr_q <= 32'h0;
            iadee_q     <= 1'b0;
            iadfe_q     <= 1'b0;
`ifdef IFR_TIMEOUT_EN
            cnt_q       <= 8'd0;
`endif
        end else begin
            case (state_q)
                IDLE, VALID: begin
`ifdef IFR_TIMEOUT_EN
                    if (drop_q && inst_data_ok) drop_q <= 1'b0;
`endif
                    if (flush || !fetch_en) begin
                        state_q <= IDLE;
                    end else if (misaligned) begin
                        state_q   <= VALID;
                        if_inst_q <= NOP_INST;
                        iadee_q   <= 1'b1;
                        iadfe_q   <= 1'b0;
                    end else if (!drop_q) begin
                        state_q     <= REQ;
                        inst_addr_q <= pc;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                REQ: begin
                    if (flush) drop_q <= 1'b1;
                    if (inst_addr_ok) begin
                        state_q <= WAIT;
`ifdef IFR_TIMEOUT_EN
                        cnt_q   <= 8'd0;
`endif
                    end
                end
                WAIT: begin
                    if (inst_data_ok) begin
                        if (drop_q || flush) begin
                            drop_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            state_q   <= VALID;
                            if_inst_q <= inst_rdata;
                            iadfe_q   <= inst_err;
                            iadee_q   <= 1'b0;
                        end
                    end
`ifdef IFR_TIMEOUT_EN
                    else if (cnt_q == TIMEOUT_CYCLES - 8'd1) begin
                        drop_q <= 1'b1;
                        if (drop_q || flush) begin
                            state_q <= IDLE;
                        end else begin
                            state_q   <= VALID;
                            if_inst_q <= NOP_INST;
                            iadfe_q   <= 1'b1;
                            iadee_q   <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                        if (flush) drop_q <= 1'b1;
                    end
`else
                    else if (flush) drop_q <= 1'b1;
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_inst_fetch_responder.sv
// tb_inst_fetch_responder: directed self-checking bench for inst_fetch_responder.
module tb_inst_fetch_responder;
    logic        clk;
    logic        reset;
    logic [31:0] pc;
    logic        fetch_en;
    logic        flush;
    logic [31:0] if_inst;
    logic        delay_hard;
    logic        IADEE;
    logic        IADFE;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        inst_err;
    int          n_cmp = 0;
    int          n_err = 0;

    inst_fetch_responder #(.NOP_INST(32'h0000_0000), .TIMEOUT_CYCLES(8'd4)) dut (
        .clk(clk), .reset(reset), .pc(pc), .fetch_en(fetch_en), .flush(flush),
        .if_inst(if_inst), .delay_hard(delay_hard), .IADEE(IADEE), .IADFE(IADFE),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata), .inst_err(inst_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic fe, input logic fl, input logic [31:0] p, input logic aok,
                       input logic dok, input logic [31:0] rd, input logic er);
        fetch_en = fe; flush = fl; pc = p;
        inst_addr_ok = aok; inst_data_ok = dok; inst_rdata = rd; inst_err = er;
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        drv(1, 0, 32'h0, 0, 0, 32'h0, 0);
        @(negedge clk);
        chk("rst_delay_hard", delay_hard, 0);
        chk("rst_inst_req", inst_req, 0);
        chk("rst_inst_addr", inst_addr, 0);
        chk("rst_if_inst", if_inst, 0);
        chk("rst_IADEE", IADEE, 0);
        chk("rst_IADFE", IADFE, 0);
        cyc;
        reset = 1'b0;
        drv(0, 0, 32'h0, 0, 0, 32'h0, 0);
        cyc;
        // aligned fetch, minimum latency, then back-to-back second fetch
        drv(1, 0, 32'hbfc0_0000, 0, 0, 32'h0, 0);
        @(negedge clk); chk("c0_delay_hard", delay_hard, 1); chk("c0_inst_req", inst_req, 0);
        cyc;
        drv(1, 0, 32'hbfc0_0000, 1, 0, 32'h0, 0);
        @(negedge clk); chk("c1_inst_req", inst_req, 1); chk("c1_inst_addr", inst_addr, 32'hbfc0_0000);
        chk("c1_delay_hard", delay_hard, 1);
        cyc;
        drv(1, 0, 32'hbfc0_0000, 0, 1, 32'h2408_0001, 0);
        @(negedge clk); chk("c2_inst_req", inst_req, 0); chk("c2_delay_hard", delay_hard, 1);
        cyc;
        drv(1, 0, 32'hbfc0_0004, 0, 0, 32'h0, 0);
        @(negedge clk); chk("c3_delay_hard", delay_hard, 0); chk("c3_if_inst", if_inst, 32'h2408_0001);
        chk("c3_IADEE", IADEE, 0); chk("c3_IADFE", IADFE, 0);
        cyc;
        drv(1, 0, 32'hbfc0_0004, 1, 0, 32'h0, 0);
        @(negedge clk); chk("b2b_inst_req", inst_req, 1); chk("b2b_inst_addr", inst_addr, 32'hbfc0_0004);
        cyc;
        drv(1, 0, 32'hbfc0_0004, 0, 1, 32'h8c09_0004, 0);
        @(negedge clk); chk("b2b_hold_if_inst", if_inst, 32'h2408_0001); chk("b2b_wait_dh", delay_hard, 1);
        cyc;
        drv(1, 1, 32'hbfc0_0008, 0, 0, 32'h0, 0);
        @(negedge clk); chk("b2b_valid_dh", delay_hard, 0); chk("b2b_if_inst", if_inst, 32'h8c09_0004);
        cyc;
        drv(0, 0, 32'hbfc0_0008, 0, 0, 32'h0, 0);
        @(negedge clk); chk("flush_valid_no_req", inst_req, 0);
        cyc;
        // misaligned fetch
        drv(1, 0, 32'hbfc0_0002, 0, 0, 32'h0, 0);
        @(negedge clk); chk("mis_dh", delay_hard, 1); chk("mis_req0", inst_req, 0);
        cyc;
        drv(1, 0, 32'hbfc0_0002, 0, 0, 32'h0, 0);
        @(negedge clk); chk("mis_valid_dh", delay_hard, 0); chk("mis_if_inst", if_inst, 0);
        chk("mis_IADEE", IADEE, 1); chk("mis_IADFE", IADFE, 0); chk("mis_req1", inst_req, 0);
        cyc;
        drv(1, 1, 32'hbfc0_0002, 0, 0, 32'h0, 0);
        @(negedge clk); chk("mis_reenter_dh", delay_hard, 0); chk("mis_reenter_IADEE", IADEE, 1);
        cyc;
        // bus error
        drv(1, 0, 32'hbfc0_0100, 0, 0, 32'h0, 0);
        @(negedge clk); chk("err_idle_dh", delay_hard, 1);
        cyc;
        drv(1, 0, 32'hbfc0_0100, 1, 0, 32'h0, 0);
        @(negedge clk); chk("err_req", inst_req, 1);
        cyc;
        drv(1, 0, 32'hbfc0_0100, 0, 1, 32'h1234_5678, 1);
        cyc;
        drv(1, 1, 32'hbfc0_0100, 0, 0, 32'h0, 0);
        @(negedge clk); chk("err_dh", delay_hard, 0); chk("err_if_inst", if_inst, 32'h1234_5678);
        chk("err_IADFE", IADFE, 1); chk("err_IADEE", IADEE, 0);
        cyc;
        // flush in WAIT discards the data beat
        drv(1, 0, 32'hbfc0_0200, 0, 0, 32'h0, 0);
        cyc;
        drv(1, 0, 32'hbfc0_0200, 1, 0, 32'h0, 0);
        cyc;
        drv(1, 1, 32'hbfc0_0200, 0, 0, 32'h0, 0);
        @(negedge clk); chk("fl_wait_dh", delay_hard, 1);
        cyc;
        drv(1, 0, 32'hbfc0_0200, 0, 1, 32'hdead_beef, 0);
        @(negedge clk); chk("fl_data_dh", delay_hard, 1);
        cyc;
        drv(1, 0, 32'hbfc0_0380, 0, 0, 32'h0, 0);
        @(negedge clk); chk("fl_idle_dh", delay_hard, 1); chk("fl_idle_req", inst_req, 0);
        chk("fl_if_inst_held", if_inst, 32'h1234_5678); chk("fl_IADFE_held", IADFE, 1);
        cyc;
        drv(1, 0, 32'hbfc0_0380, 1, 0, 32'h0, 0);
        @(negedge clk); chk("fl_next_req", inst_req, 1); chk("fl_next_addr", inst_addr, 32'hbfc0_0380);
        cyc;
        drv(1, 0, 32'hbfc0_0380, 0, 1, 32'h3c1d_bfc0, 0);
        cyc;
        drv(1, 1, 32'hbfc0_0380, 0, 0, 32'h0, 0);
        @(negedge clk); chk("fl_next_dh", delay_hard, 0); chk("fl_next_if_inst", if_inst, 32'h3c1d_bfc0);
        chk("fl_next_IADFE", IADFE, 0);
        cyc;
`ifdef IFR_TIMEOUT_EN
        // timeout after 4 WAIT cycles, late beat absorbed before the next request
        drv(1, 0, 32'hbfc0_0400, 0, 0, 32'h0, 0);
        cyc;
        drv(1, 0, 32'hbfc0_0400, 1, 0, 32'h0, 0);
        cyc;
        for (int i = 0; i < 4; i++) begin
            drv(1, 0, 32'hbfc0_0400, 0, 0, 32'h0, 0);
            @(negedge clk); chk("to_wait_dh", delay_hard, 1);
            cyc;
        end
        drv(1, 0, 32'hbfc0_0500, 0, 0, 32'h0, 0);
        @(negedge clk); chk("to_valid_dh", delay_hard, 0); chk("to_if_inst", if_inst, 0);
        chk("to_IADFE", IADFE, 1); chk("to_IADEE", IADEE, 0);
        cyc;
        @(negedge clk); chk("to_blocked_req", inst_req, 0); chk("to_blocked_dh", delay_hard, 1);
        cyc;
        drv(1, 0, 32'hbfc0_0500, 0, 1, 32'hcafe_f00d, 0);
        @(negedge clk); chk("to_late_req", inst_req, 0);
        cyc;
        drv(1, 0, 32'hbfc0_0500, 0, 0, 32'h0, 0);
        @(negedge clk); chk("to_after_req", inst_req, 0);
        cyc;
        @(negedge clk); chk("to_new_req", inst_req, 1); chk("to_new_addr", inst_addr, 32'hbfc0_0500);
        chk("to_late_discarded", if_inst, 0);
        drv(1, 0, 32'hbfc0_0500, 1, 0, 32'h0, 0);
        cyc;
        drv(1, 0, 32'hbfc0_0500, 0, 1, 32'h0000_1111, 0);
        cyc;
        drv(1, 1, 32'hbfc0_0500, 0, 0, 32'h0, 0);
        @(negedge clk); chk("to_new_if_inst", if_inst, 32'h0000_1111); chk("to_new_IADFE", IADFE, 0);
        cyc;
`endif
        drv(0, 0, 32'h0, 0, 0, 32'h0, 0);
        cyc;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/inst_fetch_responder.md
# inst_fetch_responder

Memory-side responder for the fetch stage: accepts the fetch PC each cycle, runs a request/accept/data handshake to the instruction SRAM bus, and returns the fetched word as `if_inst`. Holds the fetch stage with `delay_hard` until data is available. Reports misaligned fetches on `IADEE` and bus or timeout faults on `IADFE`. Sits between the IF stage and the instruction-side bus bridge.

## Interface
- `NOP_INST`, default 32'h0000_0000: word returned on faulted or misaligned fetch.
- `TIMEOUT_CYCLES`, default 255: WAIT-state cycles before a fetch is declared failed. Used only with `IFR_TIMEOUT_EN`; width 8 bits.
- `clk`  in  1  clock; all state changes on posedge.
- `reset`  in  1  asynchronous, active-high reset.
- `pc`  in  32  fetch address from IF; sampled when a request starts.
- `fetch_en`  in  1  IF requests a fetch this cycle.
- `flush`  in  1  discard any outstanding fetch (interrupt / pipeline clean).
- `if_inst`  out  32  fetched instruction; valid in the cycle `delay_hard`=0 with `fetch_en`=1.
- `delay_hard`  out  1  stall to IF. Combinational: `fetch_en & (state!=VALID)`; forced 0 during reset.
- `IADEE`  out  1  address-error flag accompanying `if_inst` (pc[1:0]!=0).
- `IADFE`  out  1  fetch-fault flag accompanying `if_inst` (bus error or timeout).
- `inst_req`  out  1  bus request; held until `inst_addr_ok`.
- `inst_addr`  out  32  registered request address, stable while `inst_req`=1.
- `inst_addr_ok`  in  1  bus accepted the address this cycle.
- `inst_data_ok`  in  1  read data valid this cycle; never in the same cycle as its own `inst_addr_ok`.
- `inst_rdata`  in  32  read data.
- `inst_err`  in  1  bus error, qualified by `inst_data_ok`.

## Operation
- States: IDLE, REQ, WAIT, VALID. Plus a `drop` flag, meaning discard the next `inst_data_ok`.
- IDLE, `fetch_en`=1, pc[1:0]==0: latch `inst_addr<=pc` and go to REQ.
- IDLE, `fetch_en`=1, pc misaligned: no bus access. Load `if_inst<=NOP_INST`, `IADEE<=1`, `IADFE<=0`, and go to VALID.
- IDLE, `fetch_en`=0: remain in IDLE. Outputs hold.
- REQ: `inst_req`=1. Go to WAIT on `inst_addr_ok`. A request is never withdrawn; `flush` in REQ only sets `drop`.
- WAIT, `inst_data_ok` with `drop`=0: `if_inst<=inst_rdata`, `IADFE<=inst_err`, `IADEE<=0`, go to VALID.
- WAIT, `inst_data_ok` with `drop`=1: clear `drop`, go to IDLE. Data is discarded.
- `flush` in WAIT sets `drop`.
- VALID: present the word for exactly one cycle.
  - Next state is REQ (new aligned request, `inst_addr<=pc`) if `fetch_en` and no `flush`.
  - Misaligned pc re-enters VALID with `IADEE` set.
  - Otherwise go to IDLE.
- `flush` in IDLE or VALID: go to IDLE, no request issued that cycle.
- `flush` in IDLE with no outstanding access: no effect beyond staying idle.
- `if_inst`, `IADEE`, `IADFE` are registered and hold their values until the next VALID entry.

## Timing
- Reset values: state IDLE, `drop`=0, `inst_req`=0, `inst_addr`=0, `if_inst`=0, `IADEE`=0, `IADFE`=0, timeout counter 0.
- Reset is effective immediately and overrides any outstanding bus transaction. The bus bridge must also be reset.
- Minimum latency: pc presented in cycle 0, `inst_addr_ok` in cycle 1, `inst_data_ok` in cycle 2, word valid (`delay_hard`=0) in cycle 3.
- Back-to-back fetches: VALID→REQ gives one instruction per 3 cycles at best.
- Misaligned pc: `delay_hard`=1 for one cycle, then VALID.
- IF holds `pc` while `delay_hard`=1. Sampling happens only at the IDLE/VALID→REQ transition.

## Configuration
- `IFR_TIMEOUT_EN` defined: an 8-bit counter runs in WAIT and resets on WAIT entry.
  - At `TIMEOUT_CYCLES` without `inst_data_ok`: go to VALID with `if_inst<=NOP_INST`, `IADFE<=1`, and set `drop`.
  - The late `inst_data_ok` is then absorbed.
  - A new request waits in IDLE/REQ until `drop` clears. REQ is not entered while `drop`=1.
- `IFR_TIMEOUT_EN` undefined: no counter; WAIT lasts until `inst_data_ok`.

## Test plan
- Aligned fetch pc=32'hbfc0_0000 → `inst_addr`=32'hbfc0_0000. addr_ok in cycle 1, data_ok with rdata=32'h2408_0001 in cycle 2 → `if_inst`=32'h2408_0001, `delay_hard`=0 in cycle 3, `IADEE`=`IADFE`=0.
- Misaligned pc=32'hbfc0_0002 → `inst_req` never asserted; next cycle `if_inst`=0, `IADEE`=1, `delay_hard`=0.
- `inst_err`=1 with data_ok → VALID with `IADFE`=1, `if_inst`=rdata.
- `flush` in WAIT, then data_ok with 32'hdead_beef → no VALID, `if_inst` unchanged, state IDLE. The next fetch (pc=32'hbfc0_0380) completes normally.
- Back-to-back fetches pc=0x…00 then 0x…04, with addr_ok/data_ok each one cycle after the previous event → two VALID cycles 3 cycles apart, correct words in order.
- With `IFR_TIMEOUT_EN` and `TIMEOUT_CYCLES`=4, withhold data_ok → VALID with `IADFE`=1, `if_inst`=`NOP_INST`. Late data_ok is dropped; a new request issues only after it.
